mem_stage_dcache: RTL and testbench

MEM_STAGE_DCACHE -- requirements
Module: mem_stage_dcache

---
 rtl/mem_stage_dcache_pkg.sv | 22 ++
 rtl/mem_stage_dcache_if.sv | 31 +++
 rtl/mem_stage_dcache_array.sv | 64 ++++++
 rtl/mem_stage_dcache.sv | 169 ++++++++++++++++
 tb/tb_mem_stage_dcache.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_dcache_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_dcache_pkg
// Shared definitions for the MEM-stage data cache: FSM state encoding and the
// address-split constants the cache geometry is derived from.
// ---------------------------------------------------------------------------
package mem_stage_dcache_pkg;

   // Byte-offset bits dropped from every address (one 32-bit word per line)
   localparam int OFFSET_BITS    = 2;
   // Word-address width left after dropping the byte offset
   localparam int WORD_ADDR_BITS = 32 - OFFSET_BITS;
   // Default geometry: 32 lines, remaining word-address bits form the tag
   localparam int DEF_INDEX_BITS = 5;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_READ_MISS  = 2'd1,
      ST_WRITE_THRU = 2'd2,
      ST_WRITE_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/mem_stage_dcache_if.sv
// ---------------------------------------------------------------------------
// mem_stage_dcache_if
// Main-memory request bus between the data cache (master) and memory (slave).
//   mem_req   : request, held until mem_ack
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : word-aligned address
//   mem_wdata : write data
//   mem_rdata : read data, valid with mem_ack
//   mem_ack   : one-cycle completion pulse
// ---------------------------------------------------------------------------
interface mem_stage_dcache_if;
   import mem_stage_dcache_pkg::*;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );

endinterface

// File: rtl/mem_stage_dcache_array.sv
// ---------------------------------------------------------------------------
// dcache_array
// Valid/tag/data storage for a direct-mapped cache, one word per line.
//   clock, reset : clock and synchronous active-high reset (clears valid only)
//   rd_idx       : combinational read index -> rd_valid, rd_tag, rd_data
//   wr_en        : synchronous write of wr_tag/wr_data into wr_idx, sets valid
// ---------------------------------------------------------------------------
module dcache_array
   import mem_stage_dcache_pkg::*;
#(
   parameter int INDEX_BITS = DEF_INDEX_BITS,
   parameter int TAG_BITS   = WORD_ADDR_BITS - INDEX_BITS
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [INDEX_BITS-1:0] rd_idx,
   output logic                  rd_valid,
   output logic [TAG_BITS-1:0]   rd_tag,
   output logic [31:0]           rd_data,
   input  logic                  wr_en,
   input  logic [INDEX_BITS-1:0] wr_idx,
   input  logic [TAG_BITS-1:0]   wr_tag,
   input  logic [31:0]           wr_data
);

   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0]    valid_q;
   logic [LINES-1:0]    valid_d;
   logic [TAG_BITS-1:0] tag_mem [LINES];
   logic [31:0]         data_mem [LINES];

   // Next valid vector: a write always leaves its line valid
   always_comb begin
      valid_d = valid_q;
      if (wr_en) begin
         valid_d[wr_idx] = 1'b1;
      end else begin
         valid_d = valid_q;
      end
   end

   // Valid bits are the only storage that is cleared by reset
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Tag and data storage, written without reset
   always_ff @(posedge clock) begin
      if (wr_en) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_mem[rd_idx];
   assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/mem_stage_dcache.sv
// ---------------------------------------------------------------------------
// mem_stage_dcache
// MEM pipeline stage with a direct-mapped, write-through, no-write-allocate
// data cache. Load hits complete in the same cycle; misses and all stores go
// to main memory over the mem bus while hit=0 stalls the pipeline.
//   clock, reset          : clock, synchronous active-high reset
//   MemRead, MemWrite     : load / store request (stores take precedence)
//   Branch, Zero          : branch resolution inputs -> PCSrc
//   ALU_result            : byte address (bits [1:0] ignored)
//   read_data_2           : store data
//   read_data, hit        : load data and "access complete" (stall when 0)
//   PCSrc                 : branch-taken select
//   mem                   : main-memory bus (master side)
// ---------------------------------------------------------------------------
module mem_stage_dcache
   import mem_stage_dcache_pkg::*;
#(
   parameter int INDEX_BITS = DEF_INDEX_BITS,
   parameter int TAG_BITS   = WORD_ADDR_BITS - INDEX_BITS
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      MemRead,
   input  logic                      MemWrite,
   input  logic                      Branch,
   input  logic                      Zero,
   input  logic [31:0]               ALU_result,
   input  logic [31:0]               read_data_2,
   output logic [31:0]               read_data,
   output logic                      hit,
   output logic                      PCSrc,
   mem_stage_dcache_if.master        mem
);

   state_t      state_q, state_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;

   logic [WORD_ADDR_BITS-1:0] look_word_s;
   logic [INDEX_BITS-1:0]     look_idx_s;
   logic [TAG_BITS-1:0]       look_tag_s;
   logic                      line_valid_s;
   logic [TAG_BITS-1:0]       line_tag_s;
   logic [31:0]               line_data_s;
   logic                      line_hit_s;
   logic                      wr_en_s;
   logic [31:0]               wr_data_s;
   logic                      unused_s;

   // Byte-offset bits carry no meaning for word accesses
   assign unused_s = ^ALU_result[OFFSET_BITS-1:0];

   // While a memory transaction is open the pipeline is stalled, so the
   // registered request address is the authoritative line for refill/update.
   assign look_word_s = (state_q == ST_IDLE) ? ALU_result[31:OFFSET_BITS]
                                             : mem_addr_q[31:OFFSET_BITS];
   assign look_idx_s  = look_word_s[INDEX_BITS-1:0];
   assign look_tag_s  = look_word_s[INDEX_BITS +: TAG_BITS];
   assign line_hit_s  = line_valid_s && (line_tag_s == look_tag_s);

   assign PCSrc = Branch & Zero;

   dcache_array #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_array (
      .clock    (clock),
      .reset    (reset),
      .rd_idx   (look_idx_s),
      .rd_valid (line_valid_s),
      .rd_tag   (line_tag_s),
      .rd_data  (line_data_s),
      .wr_en    (wr_en_s & ~reset),   // a reset edge abandons any refill/update
      .wr_idx   (look_idx_s),
      .wr_tag   (look_tag_s),
      .wr_data  (wr_data_s)
   );

   // Next-state, memory-request capture, array write and pipeline outputs
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      hit         = 1'b0;
      read_data   = 32'd0;
      wr_en_s     = 1'b0;
      wr_data_s   = mem.mem_rdata;
      case (state_q)
         ST_IDLE: begin
            if (MemWrite) begin
               state_d     = ST_WRITE_THRU;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = {ALU_result[31:OFFSET_BITS], 2'b00};
               mem_wdata_d = read_data_2;
            end else if (MemRead) begin
               if (line_hit_s) begin
                  hit       = 1'b1;
                  read_data = line_data_s;
               end else begin
                  state_d    = ST_READ_MISS;
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = {ALU_result[31:OFFSET_BITS], 2'b00};
               end
            end else begin
               hit = 1'b1;
            end
         end
         ST_READ_MISS: begin
            if (mem.mem_ack) begin
               wr_en_s   = 1'b1;
               wr_data_s = mem.mem_rdata;
               mem_req_d = 1'b0;
               state_d   = ST_IDLE;
            end else begin
               state_d = ST_READ_MISS;
            end
         end
         ST_WRITE_THRU: begin
            if (mem.mem_ack) begin
               // No allocate: only a line already holding this address is updated
               wr_en_s   = line_hit_s;
               wr_data_s = mem_wdata_q;
               mem_req_d = 1'b0;
               state_d   = ST_WRITE_DONE;
            end else begin
               state_d = ST_WRITE_THRU;
            end
         end
         ST_WRITE_DONE: begin
            // One release cycle; leaving unconditionally avoids re-issuing the held store
            hit     = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State and memory-bus registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_stage_dcache.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_dcache
// Self-checking bench for mem_stage_dcache: a behavioural memory with
// programmable latency answers the cache, and expected load data is queued
// when a load is issued and compared when the stage reports completion.
// ---------------------------------------------------------------------------
module tb_mem_stage_dcache;

   typedef struct packed {
      int          stall;
      logic [31:0] rdata;
      logic [31:0] req_addr;
      logic [31:0] req_wdata;
      logic        req_we;
      logic        saw_req;
      logic        stable;
      logic        pcs_ok;
      logic        tmo;
   } acc_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic        Branch = 1'b0;
   logic        Zero = 1'b0;
   logic [31:0] ALU_result = 32'd0;
   logic [31:0] read_data_2 = 32'd0;
   logic [31:0] read_data;
   logic        hit;
   logic        PCSrc;

   int tests_run = 0;
   int tests_failed = 0;

   logic [31:0] mem_model [logic [31:0]];
   logic [31:0] exp_q [$];
   int          mem_lat = 1;
   int          lat_cnt = 0;
   int          wr_count = 0;
   bit          mem_auto = 1'b1;

   mem_stage_dcache_if mif ();

   mem_stage_dcache dut (
      .clock       (clock),
      .reset       (reset),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .Branch      (Branch),
      .Zero        (Zero),
      .ALU_result  (ALU_result),
      .read_data_2 (read_data_2),
      .read_data   (read_data),
      .hit         (hit),
      .PCSrc       (PCSrc),
      .mem         (mif)
   );

   always #5 clock = ~clock;

   initial begin
      mif.mem_ack   = 1'b0;
      mif.mem_rdata = 32'd0;
   end

   // Behavioural memory: acks after mem_lat request cycles, one-cycle pulse
   always @(negedge clock) begin
      if (mem_auto) begin
         if (mif.mem_ack) begin
            mif.mem_ack = 1'b0;
            lat_cnt = 0;
         end else if (mif.mem_req === 1'b1) begin
            lat_cnt++;
            if (lat_cnt >= mem_lat) begin
               mif.mem_ack = 1'b1;
               if (mif.mem_we) begin
                  mem_model[mif.mem_addr] = mif.mem_wdata;
                  wr_count++;
               end else begin
                  mif.mem_rdata = mem_model[mif.mem_addr];
               end
            end
         end
      end
   end

   // Drive one access from posedge+1 and hold it until hit=1 (bounded)
   task automatic issue_access(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, output acc_t r);
      r = '0;
      r.stable = 1'b1;
      r.pcs_ok = 1'b1;
      MemRead = rd; MemWrite = wr; ALU_result = addr; read_data_2 = wdata;
      while (1'b1) begin
         @(negedge clock);
         if (PCSrc !== (Branch & Zero)) r.pcs_ok = 1'b0;
         if (mif.mem_req === 1'b1) begin
            if (!r.saw_req) begin
               r.saw_req = 1'b1;
               r.req_addr = mif.mem_addr; r.req_we = mif.mem_we; r.req_wdata = mif.mem_wdata;
            end else if (mif.mem_addr !== r.req_addr || mif.mem_we !== r.req_we ||
                         mif.mem_wdata !== r.req_wdata) begin
               r.stable = 1'b0;
            end
         end
         if (hit === 1'b1) begin
            r.rdata = read_data;
            break;
         end
         r.stall++;
         if (r.stall > 100) begin
            r.tmo = 1'b1;
            break;
         end
      end
      @(posedge clock); #1;
      MemRead = 1'b0; MemWrite = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      tests_run++; if (mif.mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req: got %b expected 0", mif.mem_req); end
      tests_run++; if (mif.mem_we !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_we: got %b expected 0", mif.mem_we); end
      tests_run++; if (mif.mem_addr !== 32'd0) begin tests_failed++; $display("FAIL reset_mem_addr: got %h expected 0", mif.mem_addr); end
      tests_run++; if (mif.mem_wdata !== 32'd0) begin tests_failed++; $display("FAIL reset_mem_wdata: got %h expected 0", mif.mem_wdata); end
      tests_run++; if (hit !== 1'b1) begin tests_failed++; $display("FAIL reset_idle_hit: got %b expected 1", hit); end
      tests_run++; if (read_data !== 32'd0) begin tests_failed++; $display("FAIL reset_idle_rdata: got %h expected 0", read_data); end
      @(posedge clock); #1;
   endtask

   task automatic test_read_miss();
      acc_t r;
      logic [31:0] e;
      mem_model[32'h40] = 32'hDEADBEEF;
      mem_lat = 3;
      exp_q.push_back(32'hDEADBEEF);
      issue_access(1'b1, 1'b0, 32'h40, 32'd0, r);
      e = exp_q.pop_front();
      tests_run++; if (r.tmo !== 1'b0) begin tests_failed++; $display("FAIL miss_timeout: got %b expected 0", r.tmo); end
      tests_run++; if (r.stall != mem_lat + 1) begin tests_failed++; $display("FAIL miss_stall: got %0d expected %0d", r.stall, mem_lat + 1); end
      tests_run++; if (r.saw_req !== 1'b1 || r.req_addr !== 32'h40) begin tests_failed++; $display("FAIL miss_req_addr: got %b/%h expected 1/40", r.saw_req, r.req_addr); end
      tests_run++; if (r.req_we !== 1'b0) begin tests_failed++; $display("FAIL miss_req_we: got %b expected 0", r.req_we); end
      tests_run++; if (r.stable !== 1'b1) begin tests_failed++; $display("FAIL miss_bus_stable: got %b expected 1", r.stable); end
      tests_run++; if (r.rdata !== e) begin tests_failed++; $display("FAIL miss_rdata: got %h expected %h", r.rdata, e); end
   endtask

   task automatic test_read_hit();
      acc_t r;
      logic [31:0] e;
      exp_q.push_back(32'hDEADBEEF);
      issue_access(1'b1, 1'b0, 32'h40, 32'd0, r);
      e = exp_q.pop_front();
      tests_run++; if (r.stall != 0) begin tests_failed++; $display("FAIL hit_stall: got %0d expected 0", r.stall); end
      tests_run++; if (r.saw_req !== 1'b0) begin tests_failed++; $display("FAIL hit_no_req: got %b expected 0", r.saw_req); end
      tests_run++; if (r.rdata !== e) begin tests_failed++; $display("FAIL hit_rdata: got %h expected %h", r.rdata, e); end
   endtask

   task automatic test_store_hit();
      acc_t r;
      logic [31:0] e;
      int wc0;
      mem_lat = 2;
      wc0 = wr_count;
      issue_access(1'b0, 1'b1, 32'h40, 32'h12345678, r);
      tests_run++; if (r.stall != mem_lat + 1) begin tests_failed++; $display("FAIL store_stall: got %0d expected %0d", r.stall, mem_lat + 1); end
      tests_run++; if (r.req_we !== 1'b1 || r.req_addr !== 32'h40 || r.req_wdata !== 32'h12345678) begin tests_failed++; $display("FAIL store_req: got we=%b addr=%h data=%h expected 1/40/12345678", r.req_we, r.req_addr, r.req_wdata); end
      tests_run++; if (r.stable !== 1'b1) begin tests_failed++; $display("FAIL store_bus_stable: got %b expected 1", r.stable); end
      @(negedge clock);
      tests_run++; if (mif.mem_req !== 1'b0) begin tests_failed++; $display("FAIL store_no_reissue: got %b expected 0", mif.mem_req); end
      tests_run++; if (wr_count - wc0 != 1) begin tests_failed++; $display("FAIL store_write_count: got %0d expected 1", wr_count - wc0); end
      tests_run++; if (mem_model[32'h40] !== 32'h12345678) begin tests_failed++; $display("FAIL store_mem_data: got %h expected 12345678", mem_model[32'h40]); end
      @(posedge clock); #1;
      exp_q.push_back(32'h12345678);
      issue_access(1'b1, 1'b0, 32'h40, 32'd0, r);
      e = exp_q.pop_front();
      tests_run++; if (r.saw_req !== 1'b0 || r.stall != 0) begin tests_failed++; $display("FAIL store_then_load_hit: got req=%b stall=%0d expected 0/0", r.saw_req, r.stall); end
      tests_run++; if (r.rdata !== e) begin tests_failed++; $display("FAIL store_then_load_rdata: got %h expected %h", r.rdata, e); end
   endtask

   task automatic test_store_no_alloc();
      acc_t r;
      logic [31:0] e;
      mem_lat = 1;
      issue_access(1'b0, 1'b1, 32'h80, 32'hCAFEF00D, r);
      tests_run++; if (r.stall != 2) begin tests_failed++; $display("FAIL nalloc_store_stall: got %0d expected 2", r.stall); end
      exp_q.push_back(32'hCAFEF00D);
      issue_access(1'b1, 1'b0, 32'h80, 32'd0, r);
      e = exp_q.pop_front();
      tests_run++; if (r.saw_req !== 1'b1 || r.stall != 2) begin tests_failed++; $display("FAIL nalloc_load_miss: got req=%b stall=%0d expected 1/2", r.saw_req, r.stall); end
      tests_run++; if (r.rdata !== e) begin tests_failed++; $display("FAIL nalloc_load_rdata: got %h expected %h", r.rdata, e); end
   endtask

   task automatic test_back_to_back_conflict();
      acc_t r;
      logic [31:0] e;
      logic [31:0] addrs [4];
      bit          miss [4];
      addrs = '{32'h40, 32'hC0, 32'h40, 32'h40};
      miss  = '{1'b1, 1'b1, 1'b1, 1'b0};
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      mem_lat = 1;
      mem_model[32'hC0] = 32'h0BADF00D;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(mem_model[addrs[i]]);
         issue_access(1'b1, 1'b0, addrs[i], 32'd0, r);
         e = exp_q.pop_front();
         tests_run++; if (r.saw_req !== miss[i]) begin tests_failed++; $display("FAIL conflict_miss[%0d]: got %b expected %b", i, r.saw_req, miss[i]); end
         tests_run++; if (r.rdata !== e) begin tests_failed++; $display("FAIL conflict_rdata[%0d]: got %h expected %h", i, r.rdata, e); end
      end
   endtask

   task automatic test_reset_mid_miss();
      mem_auto = 1'b0;
      MemRead = 1'b1; ALU_result = 32'h100;
      @(negedge clock);
      tests_run++; if (hit !== 1'b0) begin tests_failed++; $display("FAIL rmm_first_hit: got %b expected 0", hit); end
      @(negedge clock);
      tests_run++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h100) begin tests_failed++; $display("FAIL rmm_req: got %b/%h expected 1/100", mif.mem_req, mif.mem_addr); end
      reset = 1'b1; mif.mem_ack = 1'b1; mif.mem_rdata = 32'h55AA55AA;
      @(negedge clock);
      tests_run++; if (mif.mem_req !== 1'b0) begin tests_failed++; $display("FAIL rmm_req_drop: got %b expected 0", mif.mem_req); end
      reset = 1'b0; mif.mem_ack = 1'b0;
      #1;
      tests_run++; if (hit !== 1'b0) begin tests_failed++; $display("FAIL rmm_line_invalid: got %b expected 0", hit); end
      MemRead = 1'b0;
      @(negedge clock);
      mif.mem_ack = 1'b1; mif.mem_rdata = 32'h99999999;
      @(negedge clock);
      mif.mem_ack = 1'b0; MemRead = 1'b1;
      #1;
      tests_run++; if (hit !== 1'b0) begin tests_failed++; $display("FAIL idle_ack_ignored: got %b expected 0", hit); end
      tests_run++; if (mif.mem_req !== 1'b0) begin tests_failed++; $display("FAIL idle_ack_no_req: got %b expected 0", mif.mem_req); end
      MemRead = 1'b0;
      lat_cnt = 0;
      mem_auto = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_pcsrc();
      acc_t r;
      logic [31:0] e;
      Branch = 1'b1; Zero = 1'b1;
      mem_lat = 2;
      mem_model[32'h200] = 32'h13579BDF;
      exp_q.push_back(32'h13579BDF);
      issue_access(1'b1, 1'b0, 32'h200, 32'd0, r);
      e = exp_q.pop_front();
      tests_run++; if (r.pcs_ok !== 1'b1) begin tests_failed++; $display("FAIL pcsrc_during_miss: got %b expected 1", r.pcs_ok); end
      tests_run++; if (r.rdata !== e) begin tests_failed++; $display("FAIL pcsrc_miss_rdata: got %h expected %h", r.rdata, e); end
      issue_access(1'b0, 1'b1, 32'h200, 32'h2468ACE0, r);
      tests_run++; if (r.pcs_ok !== 1'b1) begin tests_failed++; $display("FAIL pcsrc_during_store: got %b expected 1", r.pcs_ok); end
      @(negedge clock);
      tests_run++; if (PCSrc !== 1'b1) begin tests_failed++; $display("FAIL pcsrc_idle: got %b expected 1", PCSrc); end
      Zero = 1'b0; #1;
      tests_run++; if (PCSrc !== 1'b0) begin tests_failed++; $display("FAIL pcsrc_zero_low: got %b expected 0", PCSrc); end
      Branch = 1'b0; Zero = 1'b1; #1;
      tests_run++; if (PCSrc !== 1'b0) begin tests_failed++; $display("FAIL pcsrc_branch_low: got %b expected 0", PCSrc); end
      Zero = 1'b0;
      @(posedge clock); #1;
   endtask

   initial begin
      test_reset();
      test_read_miss();
      test_read_hit();
      test_store_hit();
      test_store_no_alloc();
      test_back_to_back_conflict();
      test_reset_mid_miss();
      test_pcsrc();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
